// File: rtl/ap_prof_pkg.sv
// Shared types and default widths for the ap_ctrl handshake profiler.
//   state_t : profiler FSM state (also exported on the debug port)
//   rec_t   : one transaction record {start_ts, latency, stall} at the
//             default widths; the top packs records in this same field order.
package ap_prof_pkg;

  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_TS_W       = 32;
  localparam int DEF_LAT_W      = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_TS_W-1:0]  start_ts;
    logic [DEF_LAT_W-1:0] latency;
    logic [DEF_LAT_W-1:0] stall;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

endpackage

// File: rtl/prof_rec_fifo.sv
// First-word-fall-through record FIFO.
//   clk, rst_n      : clock, synchronous active-low reset
//   clr             : synchronous flush (same effect as reset)
//   push, wdata     : write request; accepted when not full, or when full
//                     and a pop happens in the same cycle
//   pop, rdata      : read request; rdata shows the head, zero when empty
//   full, empty     : occupancy flags
//   count           : number of stored records (0..DEPTH)
module prof_rec_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a write when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ap_ctrl_profiler.sv
// Passive profiler for an ap_ctrl_hs/chain handshake.
// Measures per-transaction latency (start to done) and post-done stall
// (done to continue), queues {start_ts, latency, stall} records in a FWFT
// FIFO and keeps running statistics.
//   ap_clk, ap_rst_n       : clock, synchronous active-low reset
//   mon_ap_*               : observed handshake (mon_ap_ready is not used)
//   prof_en, prof_clr      : enable (sampled in IDLE), synchronous clear
//   rec_*                  : record stream, valid/ready
//   txn_cnt, lat_min/max   : statistics over every record, dropped or not
//   drop_cnt, overflow     : records lost to a full FIFO
//   rec_count, dbg_state   : FIFO occupancy and FSM state for observation
//
// Handshake: a record transfers on a cycle where rec_valid and rec_ready are
// both high; rec_valid stays high with stable data until that happens.
//
// Latency counts clock edges from the start cycle to the done cycle, so a
// start at cyc=5 with done at cyc=12 gives 7. Stall counts the cycles spent
// in DONE_WAIT up to and including the continue cycle.
module ap_ctrl_profiler
  import ap_prof_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TS_W       = DEF_TS_W,
  parameter int LAT_W      = DEF_LAT_W
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          mon_ap_start,
  input  logic                          mon_ap_ready,
  input  logic                          mon_ap_done,
  input  logic                          mon_ap_continue,
  input  logic                          prof_en,
  input  logic                          prof_clr,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [TS_W-1:0]               rec_start_ts,
  output logic [LAT_W-1:0]              rec_latency,
  output logic [LAT_W-1:0]              rec_stall,
  output logic [31:0]                   txn_cnt,
  output logic [LAT_W-1:0]              lat_min,
  output logic [LAT_W-1:0]              lat_max,
  output logic [15:0]                   drop_cnt,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   rec_count,
  output state_t                        dbg_state
);

  localparam int RW = TS_W + 2 * LAT_W;

  state_t           state, state_d;
  logic [TS_W-1:0]  cyc;
  logic [TS_W-1:0]  start_ts, start_ts_d;
  logic [LAT_W-1:0] lat, lat_d, lat_inc;
  logic [LAT_W-1:0] stall, stall_d, stall_inc;

  logic             push;
  logic             restart;
  logic [TS_W-1:0]  push_ts;
  logic [LAT_W-1:0] push_lat;
  logic [LAT_W-1:0] push_stall;
  logic             drop;

  logic             fifo_full;
  logic             fifo_empty;
  logic [RW-1:0]    fifo_rdata;

  // The ready strobe carries no information the profiler needs.
  logic             unused_ready;
  assign unused_ready = mon_ap_ready;

  assign lat_inc   = (&lat)   ? lat   : lat   + LAT_W'(1);
  assign stall_inc = (&stall) ? stall : stall + LAT_W'(1);

  // Full means non-empty, so a pop happens exactly when rec_ready is high.
  assign drop      = push && fifo_full && !rec_ready;
  assign dbg_state = state;

  always_comb begin
    state_d    = state;
    start_ts_d = start_ts;
    lat_d      = lat;
    stall_d    = stall;
    push       = 1'b0;
    restart    = 1'b0;
    push_ts    = start_ts;
    push_lat   = lat_inc;
    push_stall = '0;

    case (state)
      IDLE: begin
        if (prof_en && mon_ap_start) begin
          if (mon_ap_done && mon_ap_continue) begin
            push     = 1'b1;
            push_ts  = cyc;
            push_lat = '0;
          end else if (mon_ap_done) begin
            state_d    = DONE_WAIT;
            start_ts_d = cyc;
            lat_d      = '0;
            stall_d    = '0;
          end else begin
            state_d    = BUSY;
            start_ts_d = cyc;
            lat_d      = '0;
          end
        end
      end
      BUSY: begin
        lat_d = lat_inc;
        if (mon_ap_done) begin
          if (mon_ap_continue) begin
            push    = 1'b1;
            state_d = IDLE;
            restart = 1'b1;
          end else begin
            // lat_d already holds the final latency; it freezes there.
            state_d = DONE_WAIT;
            stall_d = '0;
          end
        end
      end
      DONE_WAIT: begin
        stall_d = stall_inc;
        if (mon_ap_continue) begin
          push       = 1'b1;
          push_lat   = lat;
          push_stall = stall_inc;
          state_d    = IDLE;
          restart    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start coinciding with the completing cycle opens the next transaction.
    if (restart && prof_en && mon_ap_start) begin
      state_d    = BUSY;
      start_ts_d = cyc;
      lat_d      = '0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || prof_clr) begin
      state    <= IDLE;
      cyc      <= '0;
      start_ts <= '0;
      lat      <= '0;
      stall    <= '0;
      txn_cnt  <= '0;
      lat_min  <= '1;
      lat_max  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      start_ts <= start_ts_d;
      lat      <= lat_d;
      stall    <= stall_d;
      if (prof_en) cyc <= cyc + TS_W'(1);
      if (push) begin
        txn_cnt <= txn_cnt + 32'd1;
        if (push_lat > lat_max) lat_max <= push_lat;
        if (push_lat < lat_min) lat_min <= push_lat;
      end
      if (drop) begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        overflow <= 1'b1;
      end
    end
  end

  prof_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .clr   (prof_clr),
    .push  (push),
    .wdata ({push_ts, push_lat, push_stall}),
    .pop   (rec_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rec_count)
  );

  assign rec_valid = !fifo_empty;
  assign {rec_start_ts, rec_latency, rec_stall} = fifo_rdata;

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// Directed bench for ap_ctrl_profiler. Expected records are queued when the
// completing handshake is driven; a negedge monitor pops and compares each
// record the DUT hands over. Statistics are checked inline.
module tb_ap_ctrl_profiler;
  import ap_prof_pkg::*;

  localparam int TS_W  = 32;
  localparam int LAT_W = 16;
  localparam int RW    = TS_W + 2 * LAT_W;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              mon_ap_start, mon_ap_ready, mon_ap_done, mon_ap_continue;
  logic              prof_en, prof_clr;
  logic              rec_valid, rec_ready;
  logic [TS_W-1:0]   rec_start_ts;
  logic [LAT_W-1:0]  rec_latency, rec_stall;
  logic [31:0]       txn_cnt;
  logic [LAT_W-1:0]  lat_min, lat_max;
  logic [15:0]       drop_cnt;
  logic              overflow;
  logic [3:0]        rec_count;
  state_t            dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc_m = 0;
  logic [RW-1:0] exp_q[$];

  ap_ctrl_profiler #(.FIFO_DEPTH(8), .TS_W(TS_W), .LAT_W(LAT_W)) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .mon_ap_start    (mon_ap_start),
    .mon_ap_ready    (mon_ap_ready),
    .mon_ap_done     (mon_ap_done),
    .mon_ap_continue (mon_ap_continue),
    .prof_en         (prof_en),
    .prof_clr        (prof_clr),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec_start_ts    (rec_start_ts),
    .rec_latency     (rec_latency),
    .rec_stall       (rec_stall),
    .txn_cnt         (txn_cnt),
    .lat_min         (lat_min),
    .lat_max         (lat_max),
    .drop_cnt        (drop_cnt),
    .overflow        (overflow),
    .rec_count       (rec_count),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // One clock; cyc_m tracks the DUT timestamp that the next edge will sample.
  task automatic step();
    @(posedge ap_clk);
    if (!ap_rst_n || prof_clr) cyc_m = 0;
    else if (prof_en)          cyc_m++;
    #1;
  endtask

  task automatic run_to(input int c);
    int guard;
    guard = 0;
    while (cyc_m < c && guard < 1000) begin
      step();
      guard++;
    end
  endtask

  task automatic hs(input logic s, input logic d, input logic c);
    mon_ap_start    = s;
    mon_ap_done     = d;
    mon_ap_continue = c;
  endtask

  task automatic push_exp(input int ts, input int lat, input int st);
    exp_q.push_back({ts[TS_W-1:0], lat[LAT_W-1:0], st[LAT_W-1:0]});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_prof();
    prof_clr = 1'b1;
    step();
    prof_clr = 1'b0;
  endtask

  task automatic drain_check(input string name);
    repeat (4) step();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [RW-1:0] got, e;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n === 1'b1 && prof_clr === 1'b0 && rec_valid === 1'b1 && rec_ready === 1'b1) begin
        got = {rec_start_ts, rec_latency, rec_stall};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rec_unexpected: got %h want none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL rec: got %h want %h", got, e);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ap_rst_n = 1'b0;
    prof_en = 1'b0; prof_clr = 1'b0; rec_ready = 1'b0; mon_ap_ready = 1'b0;
    hs(0, 0, 0);
    repeat (2) step();
    chk("rst_valid",    64'(rec_valid),    64'd0);
    chk("rst_ts",       64'(rec_start_ts), 64'd0);
    chk("rst_txn",      64'(txn_cnt),      64'd0);
    chk("rst_lat_min",  64'(lat_min),      64'hFFFF);
    chk("rst_lat_max",  64'(lat_max),      64'd0);
    chk("rst_drop",     64'(drop_cnt),     64'd0);
    chk("rst_ovf",      64'(overflow),     64'd0);
    chk("rst_state",    64'(dbg_state),    64'(IDLE));
    ap_rst_n = 1'b1;
    step();
    prof_en = 1'b1; rec_ready = 1'b1;

    // start at 5, done+continue at 12
    run_to(5);
    hs(1, 0, 0); step(); hs(0, 0, 0);
    chk("t1_busy", 64'(dbg_state), 64'(BUSY));
    mon_ap_ready = 1'b1; step(); mon_ap_ready = 1'b0;
    run_to(12);
    push_exp(5, 7, 0);
    hs(0, 1, 1); step(); hs(0, 0, 0);
    chk("t1_idle", 64'(dbg_state), 64'(IDLE));
    drain_check("t1_drain");
    chk("t1_txn",     64'(txn_cnt), 64'd1);
    chk("t1_lat_min", 64'(lat_min), 64'd7);
    chk("t1_lat_max", 64'(lat_max), 64'd7);

    // start 3, done 6 without continue, continue at 10
    clear_prof();
    chk("clr_txn",     64'(txn_cnt), 64'd0);
    chk("clr_lat_min", 64'(lat_min), 64'hFFFF);
    run_to(3);
    hs(1, 0, 0); step(); hs(0, 0, 0);
    run_to(6);
    hs(0, 1, 0); step(); hs(0, 0, 0);
    chk("t2_dwait", 64'(dbg_state), 64'(DONE_WAIT));
    run_to(10);
    push_exp(3, 3, 4);
    hs(0, 0, 1); step(); hs(0, 0, 0);
    drain_check("t2_drain");
    chk("t2_txn", 64'(txn_cnt), 64'd1);

    // zero-latency at 20, start at 21, back-to-back at 23, done at 26
    clear_prof();
    run_to(20);
    push_exp(20, 0, 0);
    hs(1, 1, 1); step();
    chk("t3_zero_idle", 64'(dbg_state), 64'(IDLE));
    hs(1, 0, 0); step(); hs(0, 0, 0);
    chk("t3_busy", 64'(dbg_state), 64'(BUSY));
    run_to(23);
    push_exp(21, 2, 0);
    hs(1, 1, 1); step(); hs(0, 0, 0);
    chk("t3_b2b_busy", 64'(dbg_state), 64'(BUSY));
    run_to(26);
    push_exp(23, 3, 0);
    hs(0, 1, 1); step(); hs(0, 0, 0);
    drain_check("t3_drain");
    chk("t3_txn",     64'(txn_cnt), 64'd3);
    chk("t3_lat_min", 64'(lat_min), 64'd0);
    chk("t3_lat_max", 64'(lat_max), 64'd3);

    // ten 2-cycle transactions into a stalled FIFO
    clear_prof();
    rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      hs(1, 0, 0); step();
      hs(0, 0, 0); step();
      if (i < 8) push_exp(3 * i, 2, 0);
      hs(0, 1, 1); step(); hs(0, 0, 0);
    end
    chk("t4_drop",  64'(drop_cnt),     64'd2);
    chk("t4_ovf",   64'(overflow),     64'd1);
    chk("t4_txn",   64'(txn_cnt),      64'd10);
    chk("t4_count", 64'(rec_count),    64'd8);
    chk("t4_head",  64'(rec_start_ts), 64'd0);

    // full FIFO: push and pop in the same cycle
    hs(1, 0, 0); step();
    hs(0, 0, 0); step();
    push_exp(30, 2, 0);
    hs(0, 1, 1); rec_ready = 1'b1; step();
    hs(0, 0, 0); rec_ready = 1'b0;
    chk("t5_count", 64'(rec_count),    64'd8);
    chk("t5_drop",  64'(drop_cnt),     64'd2);
    chk("t5_txn",   64'(txn_cnt),      64'd11);
    chk("t5_head",  64'(rec_start_ts), 64'd3);
    rec_ready = 1'b1;
    repeat (8) step();
    drain_check("t5_drain");
    chk("t5_empty", 64'(rec_valid), 64'd0);

    // reset in the middle of a transaction
    hs(1, 0, 0); step(); hs(0, 0, 0);
    step(); step();
    chk("t6_busy", 64'(dbg_state), 64'(BUSY));
    ap_rst_n = 1'b0; step(); ap_rst_n = 1'b1;
    chk("t6_idle", 64'(dbg_state), 64'(IDLE));
    chk("t6_ovf",  64'(overflow),  64'd0);
    chk("t6_txn0", 64'(txn_cnt),   64'd0);
    hs(1, 0, 0); step(); hs(0, 0, 0);
    run_to(4);
    push_exp(0, 4, 0);
    hs(0, 1, 1); step(); hs(0, 0, 0);
    drain_check("t6_drain");
    chk("t6_txn",     64'(txn_cnt), 64'd1);
    chk("t6_lat_min", 64'(lat_min), 64'd4);
    chk("t6_lat_max", 64'(lat_max), 64'd4);

    // prof_en low: starts ignored in IDLE, open transaction still recorded
    prof_en = 1'b0;
    hs(1, 0, 0); step(); hs(0, 0, 0);
    chk("t7_ignored", 64'(dbg_state), 64'(IDLE));
    prof_en = 1'b1;
    begin
      int c0;
      c0 = cyc_m;
      hs(1, 0, 0); step(); hs(0, 0, 0);
      prof_en = 1'b0;
      step(); step();
      push_exp(c0, 3, 0);
      hs(0, 1, 1); step(); hs(0, 0, 0);
    end
    drain_check("t7_drain");
    chk("t7_txn", 64'(txn_cnt), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
